// File: rtl/memory_pkg.sv
// memory_pkg: shared definitions for banked_memory.
//   - default geometry (address width, data width, read port count)
//   - clear sequencer state encoding
//   - even-parity helper (only when PARITY_EN is defined)
package memory_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_READ_PORTS = 2;

  typedef enum logic {
    CLEAR,
    READY
  } clear_state_e;

`ifdef PARITY_EN
  // Even parity bit for a data word zero-extended to 64 bits; zero
  // extension does not change the XOR reduction.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/memory_clear_sequencer.sv
// memory_clear_sequencer: scrubs the array one cell per cycle after reset.
//   clock         in  single clock, rising edge
//   reset         in  synchronous active-high; restarts the scrub at cell 0
//   busy          out high while the scrub is in progress (state register)
//   clear_we      out write strobe for the scrub write
//   clear_address out cell being scrubbed this cycle
module memory_clear_sequencer
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  busy,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_address
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  clear_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // While reset is held the pointer sits at 0 and no cell is written;
  // the first scrub write lands on the first edge with reset low.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clear_we = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_we = !reset;
        if (ptr_q == LAST_PTR) begin
          state_d = READY;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign busy          = (state_q == CLEAR);
  assign clear_address = ptr_q;

endmodule

// File: rtl/banked_memory.sv
// banked_memory: one synchronous write port, READ_PORTS registered read
// ports with write-first bypass, and a hardware clear after reset.
//   clock, reset        single clock; synchronous active-high reset
//   write_enable/address/data, write_ready (= !busy)
//   read_enable[p], read_address (packed, port p at [p*ADDR_WIDTH +: ADDR_WIDTH])
//   read_data (packed, registered), read_valid[p], busy
//   parity_error[p]     only when PARITY_EN is defined
// Optional feature macro: PARITY_EN (stores an even-parity bit per cell).
module banked_memory
  import memory_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned           READ_PORTS  = DEF_READ_PORTS,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  output logic                             write_ready,
  input  logic [READ_PORTS-1:0]            read_enable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_valid,
  output logic                             busy
`ifdef PARITY_EN
  ,
  output logic [READ_PORTS-1:0]            parity_error
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
`ifdef PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif

  logic [MEM_W-1:0] mem [DEPTH];

  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_address;
  logic                  user_we;
  logic [MEM_W-1:0]      user_word, clear_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_W-1:0]      mem_word;
  logic [MEM_W-1:0]      rd_word [READ_PORTS];

  logic [READ_PORTS*DATA_WIDTH-1:0] read_data_q;
  logic [READ_PORTS-1:0]            read_valid_q;

  memory_clear_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clock         (clock),
    .reset         (reset),
    .busy          (busy),
    .clear_we      (clear_we),
    .clear_address (clear_address)
  );

  assign write_ready = !busy;
  // The reset edge must leave the array untouched, so writes are gated by it.
  assign user_we     = write_enable && write_ready && !reset;

`ifdef PARITY_EN
  assign user_word  = {even_parity(64'(write_data)), write_data};
  assign clear_word = {even_parity(64'(CLEAR_VALUE)), CLEAR_VALUE};
`else
  assign user_word  = write_data;
  assign clear_word = CLEAR_VALUE;
`endif

  // Scrub and user writes never coincide: user writes need !busy.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = write_address;
    mem_word = user_word;
    if (clear_we) begin
      mem_we   = 1'b1;
      mem_addr = clear_address;
      mem_word = clear_word;
    end else if (user_we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_word;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_word[p] = mem[read_address[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

`ifdef PARITY_EN
  logic [READ_PORTS-1:0] parity_error_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      read_data_q  <= '0;
      read_valid_q <= '0;
`ifdef PARITY_EN
      parity_error_q <= '0;
`endif
    end else begin
      for (int unsigned p = 0; p < READ_PORTS; p++) begin
        if (!busy && read_enable[p]) begin
          read_valid_q[p] <= 1'b1;
          if (user_we && (write_address == read_address[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            read_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= write_data;
`ifdef PARITY_EN
            parity_error_q[p] <= 1'b0;
`endif
          end else begin
            read_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p][DATA_WIDTH-1:0];
`ifdef PARITY_EN
            parity_error_q[p] <= even_parity(64'(rd_word[p][DATA_WIDTH-1:0]))
                                 != rd_word[p][DATA_WIDTH];
`endif
          end
        end else begin
          read_valid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
`ifdef PARITY_EN
  assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_banked_memory.sv
// tb_banked_memory: scoreboard bench for banked_memory (default geometry).
module tb_banked_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [7:0]  write_address;
  logic [7:0]  write_data;
  logic        write_ready;
  logic [1:0]  read_enable;
  logic [15:0] read_address;
  logic [15:0] read_data;
  logic [1:0]  read_valid;
  logic        busy;
`ifdef PARITY_EN
  logic [1:0]  parity_error;
`endif

  banked_memory #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8),
    .READ_PORTS  (2),
    .CLEAR_VALUE (8'h00)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .write_ready   (write_ready),
    .read_enable   (read_enable),
    .read_address  (read_address),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .busy          (busy)
`ifdef PARITY_EN
    ,
    .parity_error  (parity_error)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned port;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every valid read result is popped from the scoreboard.
  always @(negedge clock) begin : monitor
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      if (read_valid[p] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid port %0d: got data %0h required no valid", p, read_data[p*8 +: 8]);
        end else begin
          e = sb.pop_front();
          if (e.port != p || read_data[p*8 +: 8] !== e.data) begin
            errors++;
            $display("FAIL read_data port %0d: got %0h required %0h (port %0d)", p, read_data[p*8 +: 8], e.data, e.port);
          end
        end
      end
    end
  end

  task automatic push(input int unsigned port, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  // Issue a read (optionally with a same-edge write) and confirm delivery.
  task automatic do_access(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                           input logic [1:0] en, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] e0, input logic [7:0] e1);
    write_enable  = we;
    write_address = wa;
    write_data    = wd;
    read_enable   = en;
    read_address  = {a1, a0};
    if (en[0]) push(0, e0);
    if (en[1]) push(1, e1);
    tick;
    write_enable = 1'b0;
    read_enable  = 2'b00;
    #5;
    chk("read_delivered", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_write(input logic [7:0] wa, input logic [7:0] wd);
    write_enable  = 1'b1;
    write_address = wa;
    write_data    = wd;
    tick;
    write_enable = 1'b0;
  endtask

  task automatic count_clear(output int n, output int vcnt);
    n = 0;
    vcnt = 0;
    while (busy === 1'b1 && n < 400) begin
      tick;
      n++;
      if (read_valid !== 2'b00) vcnt++;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, vcnt;
    reset         = 1'b1;
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    read_enable   = '0;
    read_address  = '0;

    tick;
    chk("reset_busy", busy, 1);
    chk("reset_valid", read_valid, 0);
    chk("reset_data", read_data, 0);
    reset = 1'b0;

    // Clear phase: writes dropped, reads never valid.
    write_enable  = 1'b1;
    write_address = 8'h05;
    write_data    = 8'hFF;
    read_enable   = 2'b11;
    read_address  = {8'h05, 8'h05};
    #1;
    chk("write_ready_clear", write_ready, 0);
    count_clear(n, vcnt);
    write_enable = 1'b0;
    read_enable  = 2'b00;
    chk("clear_edges", n, 256);
    chk("clear_no_valid", vcnt, 0);
    chk("write_ready_ready", write_ready, 1);

    do_access(1'b0, 8'h00, 8'h00, 2'b11, 8'h05, 8'hFF, 8'h00, 8'h00);

    // Plain write then read.
    do_write(8'h10, 8'hA5);
    do_access(1'b0, 8'h00, 8'h00, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
    tick;
    chk("hold_data", read_data[7:0], 8'hA5);
    chk("hold_valid_low", read_valid, 0);

    // Same-edge write with both ports reading it: write-first bypass.
    do_access(1'b1, 8'h20, 8'h3C, 2'b11, 8'h20, 8'h20, 8'h3C, 8'h3C);
    do_access(1'b0, 8'h00, 8'h00, 2'b11, 8'h20, 8'h10, 8'h3C, 8'hA5);

    // Mid-clear reset: stored 0x77 must be scrubbed.
    do_write(8'hC8, 8'h77);
    do_access(1'b0, 8'h00, 8'h00, 2'b10, 8'h00, 8'hC8, 8'h00, 8'h77);
    reset = 1'b1;
    tick;
    chk("reset2_data", read_data, 0);
    chk("reset2_busy", busy, 1);
    reset = 1'b0;
    repeat (100) tick;
    chk("midclear_busy", busy, 1);
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    count_clear(n, vcnt);
    chk("reclear_edges", n, 256);
    do_access(1'b0, 8'h00, 8'h00, 2'b11, 8'hC8, 8'h10, 8'h00, 8'h00);

`ifdef PARITY_EN
    do_write(8'h01, 8'h5A);
    do_write(8'h02, 8'h33);
    dut.mem[1] = dut.mem[1] ^ 9'h001;
    do_access(1'b0, 8'h00, 8'h00, 2'b11, 8'h01, 8'h02, 8'h5B, 8'h33);
    chk("parity_error", parity_error, 2'b01);
    do_access(1'b1, 8'h01, 8'h5A, 2'b01, 8'h01, 8'h00, 8'h5A, 8'h00);
    chk("parity_bypass", parity_error[0], 0);
`endif

    tick;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
